mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates one shared memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- The LSU side carries the mem_ren/mem_wen/wmask/address outputs produced by the execute stage.
- Allows one outstanding transaction; sequences request, grant and response with a 3-state FSM.
- Sits between IFU/LSU and the memory/bus bridge.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width of all ports
CNT_WIDTH, 8, width of timeout counter (used only with MEM_ARB_TIMEOUT_EN)
TIMEOUT, 255, cycles allowed in REQ+RSP before an error response (used only with MEM_ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ifu_req_valid  in  1  IFU read request
ifu_req_ready  out  1  IFU request accepted this cycle
ifu_addr  in  ADDR_WIDTH  IFU fetch address
ifu_rsp_valid  out  1  IFU response pulse
ifu_rdata  out  DATA_WIDTH  IFU read data
ifu_rsp_err  out  1  IFU response error
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_addr  in  ADDR_WIDTH  LSU address
lsu_wen  in  1  1 = write, 0 = read
lsu_wdata  in  DATA_WIDTH  write data
lsu_wmask  in  4  byte write mask
lsu_rsp_valid  out  1  LSU response pulse
lsu_rdata  out  DATA_WIDTH  LSU read data
lsu_rsp_err  out  1  LSU response error
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_WIDTH  latched address
mem_wen  out  1  latched write enable
mem_wdata  out  DATA_WIDTH  latched write data
mem_wmask  out  4  latched mask; 0 for IFU
mem_rsp_valid  in  1  memory response
mem_rdata  in  DATA_WIDTH  memory read data
mem_rsp_err  in  1  memory error
owner  out  1  0 = IFU, 1 = LSU (valid when busy)
busy  out  1  FSM not IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE; last_grant=0 (IFU); owner=0; all latched mem_* registers cleared to 0; all *_ready/*_valid/*_err outputs 0. Any in-flight transaction is abandoned with no response.
- States: IDLE, REQ, RSP.
- IDLE:
  - Grant is combinational and goes to at most one master.
  - Only LSU valid: LSU wins. Only IFU valid: IFU wins.
  - Both valid: the master not in last_grant wins. Because last_grant resets to IFU, LSU wins the first contention.
  - The winner's *_req_ready=1 in the same cycle.
  - On the clock edge: latch addr/wen/wdata/wmask (IFU: wen=0, wmask=0, wdata=0); set owner and last_grant to the winner; go to REQ.
- REQ:
  - mem_req_valid=1, with mem_* held stable.
  - mem_req_ready=1 -> RSP next cycle.
  - Both *_req_ready=0.
- RSP:
  - mem_req_valid=0.
  - When mem_rsp_valid=1: the owner's *_rsp_valid=1, *_rdata=mem_rdata, *_rsp_err=mem_rsp_err in the same cycle (combinational, zero added latency); next state IDLE.
  - Non-owner rsp outputs stay 0.
  - Write responses also pulse rsp_valid; rdata is forwarded unchanged.
- Minimum occupancy per transaction: 3 cycles (grant, REQ, RSP) when memory responds immediately. A new grant is possible in the cycle after the response.
- mem_rsp_valid in IDLE or REQ is ignored.
- Requests arriving while busy stay pending; masters hold valid and inputs until ready.
- Masters always accept responses; there is no response backpressure.
- busy=1 in REQ and RSP.

Optional Feature:
MEM_ARB_TIMEOUT_EN
- Defined:
  - A CNT_WIDTH counter clears on entry to REQ and increments each cycle in REQ/RSP.
  - When counter==TIMEOUT and no mem_rsp_valid that cycle: the owner gets rsp_valid=1, rsp_err=1, rdata=0; mem_req_valid drops; next state IDLE.
  - A real response in the same cycle as the timeout takes priority.
  - A late response after timeout is ignored.
- Undefined: no counter logic; the FSM waits indefinitely in REQ/RSP.

Test Plan:
- IFU alone: ifu_addr=0x80000000, mem_req_ready=1 and mem_rsp_valid=1 with rdata=0x00000413 one cycle later -> ifu_req_ready in grant cycle, mem_wmask=0, ifu_rsp_valid pulse with ifu_rdata=0x00000413, owner=0.
- Contention after reset: both valid in same cycle -> LSU granted first (owner=1). After its response, IFU is granted while LSU re-requests. Grants alternate LSU, IFU, LSU.
- LSU store: addr=0x80001004, wen=1, wdata=0xDEADBEEF, wmask=4'b0011, mem_req_ready held 0 for 3 cycles -> mem_* stable all 4 REQ cycles, lsu_rsp_valid pulses on response, ifu_rsp_valid stays 0.
- Reset mid-RSP: rst_n low for 1 cycle while busy -> immediately busy=0, mem_req_valid=0, no rsp pulse. A later mem_rsp_valid is ignored.
- Error pass-through: mem_rsp_err=1 on LSU load -> lsu_rsp_err=1 for exactly one cycle.
- Timeout (macro defined, TIMEOUT=4): mem_req_ready never asserted -> owner gets rsp_valid=1, rsp_err=1, rdata=0 on the 5th cycle after entering REQ; FSM returns to IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the IFU (read-only) and the LSU
// (read/write). It allows one outstanding transaction, sequenced as grant,
// request and response by a three-state FSM. The idle grant is combinational
// and round-robin under contention.
// Optional build macro: MEM_ARB_TIMEOUT_EN. When it is defined, a transaction
// that stays in REQ/RSP until the counter reaches TIMEOUT ends with an error
// response.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 8,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // IFU
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0] ifu_addr,
  output logic                  ifu_rsp_valid,
  output logic [DATA_WIDTH-1:0] ifu_rdata,
  output logic                  ifu_rsp_err,
  // LSU
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic                  lsu_wen,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  input  logic [3:0]            lsu_wmask,
  output logic                  lsu_rsp_valid,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic                  lsu_rsp_err,
  // Memory
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wmask,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rsp_err,
  // Status
  output logic                  owner,
  output logic                  busy
);

  typedef enum logic [1:0] {StIdle, StReq, StRsp} state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;       // 0 = IFU, 1 = LSU
  logic                  last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wen_q, wen_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            wmask_q, wmask_d;

  logic                  grant_lsu, grant_ifu;
  logic                  rsp_fire, rsp_err;
  logic [DATA_WIDTH-1:0] rsp_data;

  // Under contention the master that did not win last time gets the port.
  assign grant_lsu = lsu_req_valid & (~ifu_req_valid | ~last_grant_q);
  assign grant_ifu = ifu_req_valid & ~grant_lsu;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [CNT_WIDTH-1:0] TimeoutCnt = TIMEOUT[CNT_WIDTH-1:0];
  localparam logic [CNT_WIDTH-1:0] CntOne     = 1;

  logic [CNT_WIDTH-1:0] cnt_q;

  // Timeout counter: cleared on entry to REQ, counts every busy cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_q == StIdle && state_d == StReq) begin
      cnt_q <= '0;
    end else if (state_q != StIdle) begin
      cnt_q <= cnt_q + CntOne;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{CNT_WIDTH, TIMEOUT};
`endif

  // Next-state, latching and handshake decode.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    addr_d        = addr_q;
    wen_d         = wen_q;
    wdata_d       = wdata_q;
    wmask_d       = wmask_q;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    mem_req_valid = 1'b0;
    rsp_fire      = 1'b0;
    rsp_err       = 1'b0;
    rsp_data      = '0;

    unique case (state_q)
      StIdle: begin
        if (grant_lsu) begin
          lsu_req_ready = 1'b1;
          owner_d       = 1'b1;
          last_grant_d  = 1'b1;
          addr_d        = lsu_addr;
          wen_d         = lsu_wen;
          wdata_d       = lsu_wdata;
          wmask_d       = lsu_wmask;
          state_d       = StReq;
        end else if (grant_ifu) begin
          ifu_req_ready = 1'b1;
          owner_d       = 1'b0;
          last_grant_d  = 1'b0;
          addr_d        = ifu_addr;
          wen_d         = 1'b0;
          wdata_d       = '0;
          wmask_d       = 4'b0000;
          state_d       = StReq;
        end
      end
      StReq: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = StRsp;
      end
      StRsp: begin
        if (mem_rsp_valid) begin
          rsp_fire = 1'b1;
          rsp_err  = mem_rsp_err;
          rsp_data = mem_rdata;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef MEM_ARB_TIMEOUT_EN
    // A real response in the same cycle wins over the timeout.
    if (state_q != StIdle && cnt_q == TimeoutCnt && !rsp_fire) begin
      mem_req_valid = 1'b0;
      rsp_fire      = 1'b1;
      rsp_err       = 1'b1;
      rsp_data      = '0;
      state_d       = StIdle;
    end
`endif
  end

  // State and latched request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b0;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= 4'b0000;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wen   = wen_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;
  assign owner     = owner_q;
  assign busy      = (state_q != StIdle);

  // Route the response to the owner only; the other side stays at zero.
  assign ifu_rsp_valid = rsp_fire & ~owner_q;
  assign ifu_rsp_err   = rsp_fire & ~owner_q & rsp_err;
  assign ifu_rdata     = (rsp_fire & ~owner_q) ? rsp_data : '0;
  assign lsu_rsp_valid = rsp_fire & owner_q;
  assign lsu_rsp_err   = rsp_fire & owner_q & rsp_err;
  assign lsu_rdata     = (rsp_fire & owner_q) ? rsp_data : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Inputs change 1 time unit after a rising
// edge, and outputs are checked 3 time units after that edge.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, mem_rsp_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        owner, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .CNT_WIDTH (8),
    .TIMEOUT   (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ifu_req_valid(ifu_req_valid),
    .ifu_req_ready(ifu_req_ready),
    .ifu_addr     (ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid),
    .ifu_rdata    (ifu_rdata),
    .ifu_rsp_err  (ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid),
    .lsu_req_ready(lsu_req_ready),
    .lsu_addr     (lsu_addr),
    .lsu_wen      (lsu_wen),
    .lsu_wdata    (lsu_wdata),
    .lsu_wmask    (lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid),
    .lsu_rdata    (lsu_rdata),
    .lsu_rsp_err  (lsu_rsp_err),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_addr     (mem_addr),
    .mem_wen      (mem_wen),
    .mem_wdata    (mem_wdata),
    .mem_wmask    (mem_wmask),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rdata    (mem_rdata),
    .mem_rsp_err  (mem_rsp_err),
    .owner        (owner),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    ifu_req_valid = 0; ifu_addr = 0;
    lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0; mem_rsp_err = 0;

    // Reset state
    tick(); tick();
    settle();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_req_valid", 32'(mem_req_valid), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_readies", 32'({ifu_req_ready, lsu_req_ready}), 0);
    rst_n = 1'b1;

    // IFU alone
    tick();
    ifu_req_valid = 1; ifu_addr = 32'h8000_0000; mem_req_ready = 1;
    settle();
    chk("ifu_grant_ready", 32'(ifu_req_ready), 1);
    chk("ifu_grant_lsu_ready", 32'(lsu_req_ready), 0);
    tick();
    ifu_req_valid = 0;
    settle();
    chk("ifu_req_valid_out", 32'(mem_req_valid), 1);
    chk("ifu_mem_addr", mem_addr, 32'h8000_0000);
    chk("ifu_mem_wmask", 32'(mem_wmask), 0);
    chk("ifu_mem_wen", 32'(mem_wen), 0);
    chk("ifu_owner", 32'(owner), 0);
    chk("ifu_busy", 32'(busy), 1);
    tick();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'h0000_0413;
    settle();
    chk("ifu_rsp_valid", 32'(ifu_rsp_valid), 1);
    chk("ifu_rdata", ifu_rdata, 32'h0000_0413);
    chk("ifu_lsu_rsp_quiet", 32'(lsu_rsp_valid), 0);
    chk("ifu_rsp_mem_req_low", 32'(mem_req_valid), 0);
    tick();
    mem_rsp_valid = 0;
    settle();
    chk("ifu_done_busy", 32'(busy), 0);
    chk("ifu_rsp_pulse_end", 32'(ifu_rsp_valid), 0);

    // Contention: LSU, then IFU, then LSU again (LSU load with error)
    ifu_req_valid = 1; ifu_addr = 32'h8000_0100;
    lsu_req_valid = 1; lsu_addr = 32'h8000_2000; lsu_wen = 0;
    settle();
    chk("cont1_lsu_ready", 32'(lsu_req_ready), 1);
    chk("cont1_ifu_ready", 32'(ifu_req_ready), 0);
    tick();
    lsu_req_valid = 0; mem_req_ready = 1;
    settle();
    chk("cont1_owner", 32'(owner), 1);
    chk("cont1_addr", mem_addr, 32'h8000_2000);
    chk("cont1_ifu_pending", 32'(ifu_req_ready), 0);
    tick();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'h1111_1111;
    lsu_req_valid = 1;
    settle();
    chk("cont1_lsu_rsp", 32'(lsu_rsp_valid), 1);
    chk("cont1_lsu_rdata", lsu_rdata, 32'h1111_1111);
    chk("cont1_ifu_rsp_quiet", 32'(ifu_rsp_valid), 0);
    chk("cont1_ifu_rdata_zero", ifu_rdata, 0);
    chk("cont1_busy_no_grant", 32'(lsu_req_ready), 0);
    tick();
    mem_rsp_valid = 0;
    settle();
    chk("cont2_ifu_ready", 32'(ifu_req_ready), 1);
    chk("cont2_lsu_ready", 32'(lsu_req_ready), 0);
    tick();
    ifu_req_valid = 0; mem_req_ready = 1;
    settle();
    chk("cont2_owner", 32'(owner), 0);
    chk("cont2_addr", mem_addr, 32'h8000_0100);
    tick();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'h2222_2222;
    settle();
    chk("cont2_ifu_rsp", 32'(ifu_rsp_valid), 1);
    tick();
    mem_rsp_valid = 0;
    settle();
    chk("cont3_lsu_ready", 32'(lsu_req_ready), 1);
    tick();
    lsu_req_valid = 0; mem_req_ready = 1;
    settle();
    chk("cont3_owner", 32'(owner), 1);
    tick();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_err = 1; mem_rdata = 32'hBAD0_BAD0;
    settle();
    chk("err_lsu_rsp_valid", 32'(lsu_rsp_valid), 1);
    chk("err_lsu_rsp_err", 32'(lsu_rsp_err), 1);
    chk("err_ifu_rsp_err", 32'(ifu_rsp_err), 0);
    tick();
    mem_rsp_valid = 0; mem_rsp_err = 0;
    settle();
    chk("err_pulse_end", 32'(lsu_rsp_err), 0);
    chk("err_busy", 32'(busy), 0);

    // LSU store with a stalled memory; the latched fields must stay stable
    lsu_req_valid = 1; lsu_addr = 32'h8000_1004; lsu_wen = 1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011;
    settle();
    chk("st_lsu_ready", 32'(lsu_req_ready), 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      lsu_req_valid = 0; lsu_addr = 32'h1234_5678; lsu_wen = 0;
      lsu_wdata = 32'h0; lsu_wmask = 4'b1100;
      mem_req_ready = (i == 3);
      mem_rsp_valid = (i == 1);  // a response during REQ is ignored
      settle();
      chk("st_req_valid", 32'(mem_req_valid), 1);
      chk("st_addr", mem_addr, 32'h8000_1004);
      chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("st_wmask", 32'(mem_wmask), 32'h3);
      chk("st_wen", 32'(mem_wen), 1);
      chk("st_no_rsp", 32'(lsu_rsp_valid), 0);
    end
    tick();
    mem_req_ready = 0; mem_rsp_valid = 0;
    settle();
    chk("st_rsp_wait_busy", 32'(busy), 1);
    chk("st_rsp_wait_req", 32'(mem_req_valid), 0);
    chk("st_rsp_wait_quiet", 32'(lsu_rsp_valid), 0);
    tick();
    mem_rsp_valid = 1; mem_rdata = 32'h0000_5A5A;
    settle();
    chk("st_lsu_rsp", 32'(lsu_rsp_valid), 1);
    chk("st_lsu_rdata", lsu_rdata, 32'h0000_5A5A);
    chk("st_ifu_quiet", 32'(ifu_rsp_valid), 0);
    tick();
    mem_rsp_valid = 0;

    // Reset while in RSP
    ifu_req_valid = 1; ifu_addr = 32'h8000_0200;
    tick();
    ifu_req_valid = 0; mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    settle();
    chk("mid_busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", 32'(busy), 0);
    chk("mid_req_valid", 32'(mem_req_valid), 0);
    chk("mid_owner", 32'(owner), 0);
    chk("mid_addr", mem_addr, 0);
    tick();
    rst_n = 1'b1;
    mem_rsp_valid = 1; mem_rdata = 32'hFFFF_FFFF;
    settle();
    chk("mid_late_ifu", 32'(ifu_rsp_valid), 0);
    chk("mid_late_lsu", 32'(lsu_rsp_valid), 0);
    tick();
    mem_rsp_valid = 0;
    ifu_req_valid = 1; lsu_req_valid = 1; lsu_wen = 0;
    settle();
    chk("mid_idle", 32'(busy), 0);
    chk("mid_lsu_first", 32'(lsu_req_ready), 1);
    tick();
    ifu_req_valid = 0; lsu_req_valid = 0; mem_req_ready = 1;
    tick();
    mem_req_ready = 0; mem_rsp_valid = 1;
    tick();
    mem_rsp_valid = 0;

`ifdef MEM_ARB_TIMEOUT_EN
    // Timeout: memory never accepts the request
    ifu_req_valid = 1; ifu_addr = 32'h8000_0300; mem_rdata = 32'hCAFE_F00D;
    tick();
    ifu_req_valid = 0;
    for (int k = 0; k < 5; k++) begin
      settle();
      if (k < 4) begin
        chk("to_wait_req", 32'(mem_req_valid), 1);
        chk("to_wait_rsp", 32'(ifu_rsp_valid), 0);
      end else begin
        chk("to_rsp_valid", 32'(ifu_rsp_valid), 1);
        chk("to_rsp_err", 32'(ifu_rsp_err), 1);
        chk("to_rdata", ifu_rdata, 0);
        chk("to_req_drop", 32'(mem_req_valid), 0);
      end
      tick();
    end
    settle();
    chk("to_idle", 32'(busy), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
